// File: rtl/host_arbiter_pkg.sv
// rtl/host_arbiter_pkg.sv - shared encodings for the host arbiter
package host_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE     = 2'd0;
    localparam arb_state_t ARB_GRANT_MH = 2'd1;
    localparam arb_state_t ARB_GRANT_SH = 2'd2;
    localparam arb_state_t ARB_GUARD    = 2'd3;

    localparam logic HOST_MAIN = 1'b0;
    localparam logic HOST_SEC  = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/host_arbiter_if.sv
// rtl/host_arbiter_if.sv - host chip-select, control and status bundle of the arbiter
// master: host/management side (drives chip-selects and controls, reads grants/status)
// slave : arbiter side
interface host_arbiter_if;
    logic       mh_cs_n;
    logic       sh_cs_n;
    logic       arb_enable;
    logic       sw_host_select;
    logic       prio_main;
    logic       clr_status;
    logic       host_select;
    logic       mh_grant;
    logic       sh_grant;
    logic       conflict_pulse;
    logic [7:0] conflict_count;
    logic       timeout_flag;

    modport master (
        output mh_cs_n, sh_cs_n, arb_enable, sw_host_select, prio_main, clr_status,
        input  host_select, mh_grant, sh_grant, conflict_pulse, conflict_count, timeout_flag
    );

    modport slave (
        input  mh_cs_n, sh_cs_n, arb_enable, sw_host_select, prio_main, clr_status,
        output host_select, mh_grant, sh_grant, conflict_pulse, conflict_count, timeout_flag
    );
endinterface

// File: rtl/host_arbiter_cs_sync.sv
// rtl/host_arbiter_cs_sync.sv - multi-flop synchronizer for one asynchronous chip-select
// Ports: clk, rst_n (sync, active-low), i_async (raw pin), o_sync (synchronized level).
// STAGES must be at least 2. Resets to RESET_VAL so a CS reads inactive out of reset.
module host_arbiter_cs_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/host_arbiter.sv
// rtl/host_arbiter.sv - per-transaction flash path arbiter between main and secondary host
// Ports: clk, rst_n (sync, active-low), bus (host_arbiter_if.slave):
//   in : mh_cs_n, sh_cs_n (async), arb_enable, sw_host_select, prio_main, clr_status
//   out: host_select (0=main), mh_grant, sh_grant, conflict_pulse,
//        conflict_count (saturating 8 bit), timeout_flag (sticky)
module host_arbiter
    import host_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    host_arbiter_if.slave bus
);

    // One down-counter serves both the grant timeout and the guard gap.
    localparam int CNT_W = $clog2(max2(TIMEOUT_CYCLES, GUARD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GRD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    logic w_mh_sync, w_sh_sync;
    logic w_mh_act, w_sh_act;
    logic w_mh_req, w_sh_req;
    logic w_mh_rise, w_sh_rise;
    logic w_in_grant, w_owner_act, w_release, w_timeout, w_conflict;
    logic w_pick;

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_host_select, r_mh_grant, r_sh_grant, r_last_grant;
    logic             r_mh_lock, r_sh_lock;
    logic             r_mh_act_d, r_sh_act_d;
    logic             r_conflict_pulse, r_timeout_flag;
    logic [7:0]       r_conflict_count;

    host_arbiter_cs_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_mh_sync (
        .clk(clk), .rst_n(rst_n), .i_async(bus.mh_cs_n), .o_sync(w_mh_sync)
    );
    host_arbiter_cs_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sh_sync (
        .clk(clk), .rst_n(rst_n), .i_async(bus.sh_cs_n), .o_sync(w_sh_sync)
    );

    assign w_mh_act  = ~w_mh_sync;
    assign w_sh_act  = ~w_sh_sync;
    // A host that timed out stays locked until it drops CS at least once.
    assign w_mh_req  = w_mh_act & ~r_mh_lock;
    assign w_sh_req  = w_sh_act & ~r_sh_lock;
    // Rising edges only: a host already active when a grant starts is not a conflict.
    assign w_mh_rise = w_mh_act & ~r_mh_act_d;
    assign w_sh_rise = w_sh_act & ~r_sh_act_d;

    assign w_in_grant  = (r_state == ARB_GRANT_MH) || (r_state == ARB_GRANT_SH);
    assign w_owner_act = (r_state == ARB_GRANT_MH) ? w_mh_act : w_sh_act;
    assign w_release   = w_in_grant & ~w_owner_act;
    // Release wins over timeout when both happen on the same cycle.
    assign w_timeout   = w_in_grant & w_owner_act & (r_cnt == '0);
    assign w_conflict  = ((r_state == ARB_GRANT_MH) & w_sh_rise) |
                         ((r_state == ARB_GRANT_SH) & w_mh_rise);

    always_comb begin
        w_pick = HOST_MAIN;
        if (w_mh_req && w_sh_req) begin
            w_pick = bus.prio_main ? HOST_MAIN : ~r_last_grant;
        end else if (w_sh_req) begin
            w_pick = HOST_SEC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ARB_IDLE;
            r_cnt            <= '0;
            r_host_select    <= HOST_MAIN;
            r_mh_grant       <= 1'b0;
            r_sh_grant       <= 1'b0;
            r_last_grant     <= HOST_SEC;
            r_mh_lock        <= 1'b0;
            r_sh_lock        <= 1'b0;
            r_mh_act_d       <= 1'b0;
            r_sh_act_d       <= 1'b0;
            r_conflict_pulse <= 1'b0;
            r_conflict_count <= 8'd0;
            r_timeout_flag   <= 1'b0;
        end else begin
            r_mh_act_d       <= w_mh_act;
            r_sh_act_d       <= w_sh_act;
            r_conflict_pulse <= w_conflict;
            r_mh_lock        <= (w_timeout && r_state == ARB_GRANT_MH) || (r_mh_lock && w_mh_act);
            r_sh_lock        <= (w_timeout && r_state == ARB_GRANT_SH) || (r_sh_lock && w_sh_act);

            // A new event in the same cycle as clr_status survives the clear.
            if (w_conflict) begin
                if (bus.clr_status) begin
                    r_conflict_count <= 8'd1;
                end else if (r_conflict_count != 8'hFF) begin
                    r_conflict_count <= r_conflict_count + 8'd1;
                end
            end else if (bus.clr_status) begin
                r_conflict_count <= 8'd0;
            end

            if (w_timeout) begin
                r_timeout_flag <= 1'b1;
            end else if (bus.clr_status) begin
                r_timeout_flag <= 1'b0;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (!bus.arb_enable) begin
                        r_host_select <= bus.sw_host_select;
                    end else if (w_mh_req || w_sh_req) begin
                        r_host_select <= w_pick;
                        r_last_grant  <= w_pick;
                        r_mh_grant    <= (w_pick == HOST_MAIN);
                        r_sh_grant    <= (w_pick == HOST_SEC);
                        r_cnt         <= TMO_LOAD;
                        r_state       <= (w_pick == HOST_SEC) ? ARB_GRANT_SH : ARB_GRANT_MH;
                    end
                end
                ARB_GRANT_MH, ARB_GRANT_SH: begin
                    if (w_release || w_timeout) begin
                        r_mh_grant <= 1'b0;
                        r_sh_grant <= 1'b0;
                        r_cnt      <= GRD_LOAD;
                        r_state    <= ARB_GUARD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == '0) begin
                        r_state <= ARB_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.host_select    = r_host_select;
    assign bus.mh_grant       = r_mh_grant;
    assign bus.sh_grant       = r_sh_grant;
    assign bus.conflict_pulse = r_conflict_pulse;
    assign bus.conflict_count = r_conflict_count;
    assign bus.timeout_flag   = r_timeout_flag;

endmodule

// File: tb/tb_host_arbiter.sv
// tb/tb_host_arbiter.sv - self-checking bench for host_arbiter
module tb_host_arbiter;

    localparam int S = 2;
    localparam int G = 4;
    localparam int T = 64;

    logic clk;
    logic rst_n;
    int   n_chk, n_pass, n_fail;

    host_arbiter_if bus ();

    host_arbiter #(.SYNC_STAGES(S), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the path, how long, plus guard time left.
    int m_phase;          // 0 idle, 1 granted, 2 guard
    int m_owner;          // 0 main, 1 secondary
    int m_age;
    int m_guard_left;
    int m_last;
    int m_count;
    int m_total;
    bit m_flag, m_pulse, m_hsel;
    bit [1:0] m_lock, m_prev;
    bit m_pipe_m[$];
    bit m_pipe_s[$];

    task automatic model_step();
        bit [1:0] act;
        bit r0, r1;
        int pick, o;
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_age = 0; m_guard_left = 0; m_last = 1;
            m_count = 0; m_flag = 0; m_pulse = 0; m_hsel = 0; m_lock = 0; m_prev = 0;
            m_pipe_m = {}; m_pipe_s = {};
            for (int i = 0; i < S; i++) begin
                m_pipe_m.push_back(1'b1);
                m_pipe_s.push_back(1'b1);
            end
            return;
        end
        act[0] = ~m_pipe_m[0];
        act[1] = ~m_pipe_s[0];
        m_pulse = 0;
        if (bus.clr_status) begin
            m_count = 0;
            m_flag = 0;
        end
        for (int h = 0; h < 2; h++) if (!act[h]) m_lock[h] = 0;
        case (m_phase)
            0: begin
                if (!bus.arb_enable) begin
                    m_hsel = bus.sw_host_select;
                end else begin
                    r0 = act[0] && !m_lock[0];
                    r1 = act[1] && !m_lock[1];
                    pick = -1;
                    if (r0 && r1) pick = bus.prio_main ? 0 : 1 - m_last;
                    else if (r0) pick = 0;
                    else if (r1) pick = 1;
                    if (pick >= 0) begin
                        m_phase = 1; m_owner = pick; m_last = pick; m_age = 0;
                        m_hsel = (pick == 1);
                    end
                end
            end
            1: begin
                o = 1 - m_owner;
                if (act[o] && !m_prev[o]) begin
                    m_pulse = 1;
                    m_total++;
                    if (m_count < 255) m_count++;
                end
                if (!act[m_owner]) begin
                    m_phase = 2; m_guard_left = G;
                end else begin
                    m_age++;
                    if (m_age == T) begin
                        m_flag = 1; m_lock[m_owner] = 1;
                        m_phase = 2; m_guard_left = G;
                    end
                end
            end
            default: begin
                m_guard_left--;
                if (m_guard_left == 0) m_phase = 0;
            end
        endcase
        m_prev = act;
        m_pipe_m.push_back(bus.mh_cs_n); void'(m_pipe_m.pop_front());
        m_pipe_s.push_back(bus.sh_cs_n); void'(m_pipe_s.pop_front());
    endtask

    function automatic logic [12:0] dut_outs();
        return {bus.host_select, bus.mh_grant, bus.sh_grant, bus.conflict_pulse,
                bus.conflict_count, bus.timeout_flag};
    endfunction

    function automatic logic [12:0] model_outs();
        return {m_hsel, m_phase == 1 && m_owner == 0, m_phase == 1 && m_owner == 1,
                m_pulse, 8'(m_count), m_flag};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("outs", 32'(dut_outs()), 32'(model_outs()));
    endtask

    function automatic bit sig(input int sel);
        case (sel)
            0: return bus.mh_grant;
            1: return bus.sh_grant;
            2: return bus.mh_grant | bus.sh_grant;
            default: return ~bus.sh_grant;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            tick();
            n++;
            if (sig(sel)) return;
        end
        n = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mh_cs_n = 1'b1; bus.sh_cs_n = 1'b1; bus.clr_status = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last, exp_owner, pulses, held, gcyc, gfirst, ftick, sh_seen, k, any;
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.mh_cs_n = 1'b1; bus.sh_cs_n = 1'b1;
        bus.arb_enable = 1'b1; bus.sw_host_select = 1'b0;
        bus.prio_main = 1'b1; bus.clr_status = 1'b0;
        #1;
        tick(); tick();
        chk("reset_outs", 32'(dut_outs()), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: grant latency and guard gap
        bus.mh_cs_n = 1'b0;
        wait_sig(0, 20, n);
        chk("t1_latency", 32'(n), 32'(S + 1));
        chk("t1_hsel", 32'(bus.host_select), 32'h0);
        repeat (40) tick();
        bus.mh_cs_n = 1'b1;
        tick(); tick();
        bus.sh_cs_n = 1'b0;
        wait_sig(1, 30, n);
        chk("t1_release_to_next_grant", 32'(n + 2), 32'(S + 1 + G + 1));
        repeat (5) tick();
        bus.sh_cs_n = 1'b1;
        repeat (15) tick();

        // 2: round-robin ties
        do_reset();
        bus.prio_main = 1'b0;
        last = 1;
        for (int r = 0; r < 3; r++) begin
            bus.mh_cs_n = 1'b0; bus.sh_cs_n = 1'b0;
            wait_sig(2, 20, n);
            exp_owner = 1 - last;
            last = exp_owner;
            chk("t2_owner", 32'(bus.sh_grant), 32'(exp_owner));
            chk("t2_conflict_count", 32'(bus.conflict_count), 32'h0);
            repeat (10) tick();
            bus.mh_cs_n = 1'b1; bus.sh_cs_n = 1'b1;
            repeat (15) tick();
        end

        // 3: conflict during a secondary grant
        do_reset();
        bus.prio_main = 1'b1;
        bus.sh_cs_n = 1'b0;
        wait_sig(1, 20, n);
        repeat (5) tick();
        bus.mh_cs_n = 1'b0;
        pulses = 0; held = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            pulses += int'(bus.conflict_pulse);
            held &= int'(bus.sh_grant);
        end
        chk("t3_pulses", 32'(pulses), 32'h1);
        chk("t3_count", 32'(bus.conflict_count), 32'h1);
        chk("t3_sh_held", 32'(held), 32'h1);
        bus.sh_cs_n = 1'b1;
        wait_sig(3, 20, n);
        chk("t3_sh_release", 32'(n), 32'(S + 1));
        bus.mh_cs_n = 1'b1;
        repeat (15) tick();

        // 4: timeout and lock-out of the timed-out host
        do_reset();
        bus.mh_cs_n = 1'b0;
        gcyc = 0; gfirst = -1; ftick = -1; sh_seen = 0;
        for (int i = 1; i <= 200; i++) begin
            if (i == 30) bus.sh_cs_n = 1'b0;
            if (i == 150) bus.sh_cs_n = 1'b1;
            tick();
            if (bus.mh_grant) begin
                gcyc++;
                if (gfirst < 0) gfirst = i;
            end
            if (bus.timeout_flag && ftick < 0) ftick = i;
            if (bus.sh_grant) sh_seen = 1;
        end
        chk("t4_grant_cycles", 32'(gcyc), 32'(T));
        chk("t4_flag_at", 32'(ftick - gfirst), 32'(T));
        chk("t4_flag", 32'(bus.timeout_flag), 32'h1);
        chk("t4_sh_granted", 32'(sh_seen), 32'h1);
        bus.mh_cs_n = 1'b1;
        repeat (15) tick();
        bus.clr_status = 1'b1; tick(); bus.clr_status = 1'b0; tick();
        chk("t4_flag_clr", 32'(bus.timeout_flag), 32'h0);

        // 5: saturation, then clear coinciding with a conflict
        do_reset();
        m_total = 0;
        k = 0;
        while (m_total < 300 && k < 40) begin
            bus.mh_cs_n = 1'b0;
            for (int i = 0; i < 50; i++) begin
                bus.sh_cs_n = ~bus.sh_cs_n;
                tick();
            end
            bus.mh_cs_n = 1'b1; bus.sh_cs_n = 1'b1;
            repeat (12) tick();
            k++;
        end
        chk("t5_saturated", 32'(bus.conflict_count), 32'd255);
        bus.mh_cs_n = 1'b0;
        wait_sig(0, 20, n);
        bus.clr_status = 1'b1;
        n = -1;
        for (int i = 0; i < 20 && n < 0; i++) begin
            bus.sh_cs_n = ~bus.sh_cs_n;
            tick();
            if (bus.conflict_pulse) n = i;
        end
        chk("t5_clr_pulse_seen", 32'(n >= 0), 32'h1);
        chk("t5_clr_vs_event", 32'(bus.conflict_count), 32'h1);
        bus.clr_status = 1'b0;
        bus.mh_cs_n = 1'b1; bus.sh_cs_n = 1'b1;
        repeat (15) tick();

        // 6: software select and reset mid-grant
        do_reset();
        bus.arb_enable = 1'b0;
        tick();
        bus.sw_host_select = 1'b1;
        tick();
        chk("t6_sw_select", 32'(bus.host_select), 32'h1);
        bus.mh_cs_n = 1'b0;
        any = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any |= int'(bus.mh_grant | bus.sh_grant);
        end
        chk("t6_no_grant", 32'(any), 32'h0);
        bus.arb_enable = 1'b1;
        wait_sig(0, 20, n);
        chk("t6_grant_after_enable", 32'(n >= 0), 32'h1);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("t6_reset_mid_grant", 32'(dut_outs()), 32'h0);
        rst_n = 1'b1;
        bus.mh_cs_n = 1'b1;
        bus.sw_host_select = 1'b0;
        repeat (5) tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) bus.mh_cs_n = ~bus.mh_cs_n;
            if ($urandom_range(0, 11) == 0) bus.sh_cs_n = ~bus.sh_cs_n;
            bus.clr_status = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0) bus.prio_main = ~bus.prio_main;
            if ($urandom_range(0, 299) == 0) bus.arb_enable = ~bus.arb_enable;
            if ($urandom_range(0, 19) == 0) bus.sw_host_select = ~bus.sw_host_select;
            rst_n = ($urandom_range(0, 1499) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
